// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI AW/AR command into per-beat address, strobe, index and LAST (FIXED/INCR/WRAP).
// Optional feature: define AXI_BURST_4K_CHECK_EN to flag INCR bursts that cross a 4 KB boundary.
module axi_burst_addr_gen #(
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                      i_aclk,
    input  logic                      i_areset,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [ID_WIDTH-1:0]       i_cmd_id,
    input  logic [ADDR_WIDTH-1:0]     i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]      i_cmd_len,
    input  logic [2:0]                i_cmd_size,
    input  logic [1:0]                i_cmd_burst,
    output logic                      o_cmd_err,
    output logic                      o_err_4k,
    output logic                      o_beat_valid,
    input  logic                      i_beat_ready,
    output logic [ID_WIDTH-1:0]       o_beat_id,
    output logic [ADDR_WIDTH-1:0]     o_beat_addr,
    output logic [DATA_WIDTH/8-1:0]   o_beat_strb,
    output logic [LEN_WIDTH-1:0]      o_beat_idx,
    output logic                      o_beat_last
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LOG2NB = $clog2(NB);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(NB - 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;
    state_t r_state, w_state_next;

    logic                    r_cmd_ready, r_cmd_err, r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr, r_wrap_mask;
    logic [LEN_WIDTH-1:0]    r_len, r_idx;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [NB-1:0]           r_strb;

    logic                    w_accept, w_advance, w_illegal, w_load;
    logic                    w_size_ok, w_wrap_len_ok, w_cmd_aligned;
    logic [LEN_WIDTH:0]      w_len_p1;
    logic [ADDR_WIDTH-1:0]   w_cmd_bytes, w_cmd_wrap_mask;
    logic [ADDR_WIDTH-1:0]   w_bytes, w_addr_incr, w_addr_wrap, w_addr_step;
    logic [ADDR_WIDTH-1:0]   w_load_addr, w_load_bytes, w_lo, w_hi;
    logic [NB-1:0]           w_strb;

    // Command legality and per-command constants
    assign w_len_p1        = {1'b0, i_cmd_len} + {{LEN_WIDTH{1'b0}}, 1'b1};
    assign w_cmd_bytes     = ADDR_WIDTH'(1) << i_cmd_size;
    assign w_cmd_wrap_mask = (ADDR_WIDTH'(w_len_p1) << i_cmd_size) - ADDR_WIDTH'(1);
    assign w_size_ok       = ({29'd0, i_cmd_size} <= 32'(LOG2NB));
    assign w_wrap_len_ok   = (i_cmd_len == LEN_WIDTH'(1)) || (i_cmd_len == LEN_WIDTH'(3)) ||
                             (i_cmd_len == LEN_WIDTH'(7)) || (i_cmd_len == LEN_WIDTH'(15));
    assign w_cmd_aligned   = ((i_cmd_addr & (w_cmd_bytes - ADDR_WIDTH'(1))) == '0);
    assign w_illegal       = (i_cmd_burst == 2'd3) || !w_size_ok ||
                             ((i_cmd_burst == 2'd2) && (!w_wrap_len_ok || !w_cmd_aligned));

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    w_accept = 1'b1;
                    if (!w_illegal) w_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (i_beat_ready) begin
                    if (r_last) w_state_next = ST_IDLE;
                    else        w_advance    = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // After beat 0 every INCR address is aligned, so realigning then adding B gives Al + n*B
    assign w_bytes     = ADDR_WIDTH'(1) << r_size;
    assign w_addr_incr = (r_addr & ~(w_bytes - ADDR_WIDTH'(1))) + w_bytes;
    assign w_addr_wrap = (r_addr & ~r_wrap_mask) | ((r_addr + w_bytes) & r_wrap_mask);

    always_comb begin
        case (r_burst)
            2'd0:    w_addr_step = r_addr;
            2'd2:    w_addr_step = w_addr_wrap;
            default: w_addr_step = w_addr_incr;
        endcase
    end

    assign w_load       = w_accept && !w_illegal;
    assign w_load_addr  = w_load ? i_cmd_addr  : w_addr_step;
    assign w_load_bytes = w_load ? w_cmd_bytes : w_bytes;
    assign w_lo         = w_load_addr & LANE_MASK;
    assign w_hi         = ((w_load_addr & ~(w_load_bytes - ADDR_WIDTH'(1))) & LANE_MASK)
                          + w_load_bytes - ADDR_WIDTH'(1);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_strb
            assign w_strb[gi] = (ADDR_WIDTH'(gi) >= w_lo) && (ADDR_WIDTH'(gi) <= w_hi);
        end
    endgenerate

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_cmd_ready <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_wrap_mask <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_strb      <= '0;
            r_last      <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_next == ST_IDLE);
            r_cmd_err   <= w_accept && w_illegal;
            if (w_load) begin
                r_id        <= i_cmd_id;
                r_addr      <= i_cmd_addr;
                r_wrap_mask <= w_cmd_wrap_mask;
                r_len       <= i_cmd_len;
                r_idx       <= '0;
                r_size      <= i_cmd_size;
                r_burst     <= i_cmd_burst;
                r_strb      <= w_strb;
                r_last      <= (i_cmd_len == '0);
            end else if (w_advance) begin
                r_addr <= w_addr_step;
                r_idx  <= r_idx + LEN_WIDTH'(1);
                r_strb <= w_strb;
                r_last <= ((r_idx + LEN_WIDTH'(1)) == r_len);
            end
        end
    end

`ifdef AXI_BURST_4K_CHECK_EN
    localparam int SPAN_W = LEN_WIDTH + 14;
    logic              r_err_4k;
    logic [11:0]       w_4k_low;
    logic [SPAN_W-1:0] w_4k_sum;

    // Offset of the aligned start within its 4 KB page plus the total burst span
    assign w_4k_low = i_cmd_addr[11:0] & ~(w_cmd_bytes[11:0] - 12'd1);
    assign w_4k_sum = SPAN_W'(w_4k_low) + (SPAN_W'(w_len_p1) << i_cmd_size);

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) r_err_4k <= 1'b0;
        else          r_err_4k <= w_load && (i_cmd_burst == 2'd1) && (w_4k_sum > SPAN_W'(4096));
    end
    assign o_err_4k = r_err_4k;
`else
    assign o_err_4k = 1'b0;
`endif

    assign o_cmd_ready  = r_cmd_ready;
    assign o_cmd_err    = r_cmd_err;
    assign o_beat_valid = (r_state == ST_BURST);
    assign o_beat_id    = r_id;
    assign o_beat_addr  = r_addr;
    assign o_beat_strb  = r_strb;
    assign o_beat_idx   = r_idx;
    assign o_beat_last  = r_last;
endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen: an 8-bit-bus and a 32-bit-bus instance share clock,
// reset and command fields; each has its own cmd_valid.
module tb_axi_burst_addr_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid8 = 1'b0, cmd_valid32 = 1'b0;
    logic [4:0]  cmd_id = '0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic        beat_ready = 1'b0;

    logic        rdy8, err8, e4k8, v8, last8;
    logic [4:0]  id8;
    logic [31:0] addr8;
    logic [0:0]  strb8;
    logic [7:0]  idx8;
    logic        rdy32, err32, e4k32, v32, last32;
    logic [4:0]  id32;
    logic [31:0] addr32;
    logic [3:0]  strb32;
    logic [7:0]  idx32;

    int n_total = 0;
    int n_bad   = 0;
    int m_sel   = 0;
    logic [31:0] exp_addr [0:15];
    logic [31:0] exp_strb [0:15];
    logic        exp_4k;

    logic        m_ready, m_err, m_e4k, m_valid, m_last;
    logic [4:0]  m_id;
    logic [31:0] m_addr, m_strb;
    logic [7:0]  m_idx;

    always #5 clk = ~clk;

    axi_burst_addr_gen #(.ID_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(8), .LEN_WIDTH(8)) u_dut8 (
        .i_aclk(clk), .i_areset(rst), .i_cmd_valid(cmd_valid8), .o_cmd_ready(rdy8),
        .i_cmd_id(cmd_id), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_size(cmd_size),
        .i_cmd_burst(cmd_burst), .o_cmd_err(err8), .o_err_4k(e4k8), .o_beat_valid(v8),
        .i_beat_ready(beat_ready), .o_beat_id(id8), .o_beat_addr(addr8), .o_beat_strb(strb8),
        .o_beat_idx(idx8), .o_beat_last(last8));

    axi_burst_addr_gen #(.ID_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) u_dut32 (
        .i_aclk(clk), .i_areset(rst), .i_cmd_valid(cmd_valid32), .o_cmd_ready(rdy32),
        .i_cmd_id(cmd_id), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_size(cmd_size),
        .i_cmd_burst(cmd_burst), .o_cmd_err(err32), .o_err_4k(e4k32), .o_beat_valid(v32),
        .i_beat_ready(beat_ready), .o_beat_id(id32), .o_beat_addr(addr32), .o_beat_strb(strb32),
        .o_beat_idx(idx32), .o_beat_last(last32));

    always_comb begin
        m_ready = (m_sel != 0) ? rdy32  : rdy8;
        m_err   = (m_sel != 0) ? err32  : err8;
        m_e4k   = (m_sel != 0) ? e4k32  : e4k8;
        m_valid = (m_sel != 0) ? v32    : v8;
        m_last  = (m_sel != 0) ? last32 : last8;
        m_id    = (m_sel != 0) ? id32   : id8;
        m_addr  = (m_sel != 0) ? addr32 : addr8;
        m_idx   = (m_sel != 0) ? idx32  : idx8;
        m_strb  = (m_sel != 0) ? {28'd0, strb32} : {31'd0, strb8};
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one edge; returns in the cycle after acceptance
    task automatic send_cmd(input int sel, input logic [4:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        m_sel = sel;
        #0;
        check_eq("ready_before_cmd", m_ready, 1);
        cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
        cmd_valid8  = (sel == 0);
        cmd_valid32 = (sel != 0);
        tick();
        cmd_valid8  = 1'b0;
        cmd_valid32 = 1'b0;
    endtask

    task automatic run_burst(input string name, input logic [4:0] id, input int n);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_valid[%0d]", name, i), m_valid, 1);
            check_eq($sformatf("%s_addr[%0d]", name, i), m_addr, exp_addr[i]);
            check_eq($sformatf("%s_strb[%0d]", name, i), m_strb, exp_strb[i]);
            check_eq($sformatf("%s_idx[%0d]", name, i), m_idx, i);
            check_eq($sformatf("%s_last[%0d]", name, i), m_last, (i == n - 1));
            check_eq($sformatf("%s_id[%0d]", name, i), m_id, id);
            check_eq($sformatf("%s_ready_busy[%0d]", name, i), m_ready, 0);
            tick();
        end
        check_eq({name, "_valid_after"}, m_valid, 0);
        check_eq({name, "_ready_after"}, m_ready, 1);
        $display("txn %s: %0d beats, first addr 0x%0h", name, n, exp_addr[0]);
    endtask

    task automatic illegal_cmd(input string name, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
        send_cmd(1, 5'd9, 32'h0000_0040, len, size, burst);
        check_eq({name, "_err"}, m_err, 1);
        check_eq({name, "_valid"}, m_valid, 0);
        check_eq({name, "_ready"}, m_ready, 1);
        tick();
        check_eq({name, "_err_gone"}, m_err, 0);
        check_eq({name, "_valid_later"}, m_valid, 0);
        $display("txn %s: rejected", name);
    endtask

    initial begin
`ifdef AXI_BURST_4K_CHECK_EN
        exp_4k = 1'b1;
`else
        exp_4k = 1'b0;
`endif
        #2;
        for (int s = 0; s < 2; s++) begin
            m_sel = s;
            #0;
            check_eq("rst_ready", m_ready, 0);
            check_eq("rst_valid", m_valid, 0);
            check_eq("rst_addr", m_addr, 0);
            check_eq("rst_strb", m_strb, 0);
            check_eq("rst_idx", m_idx, 0);
            check_eq("rst_last", m_last, 0);
            check_eq("rst_id", m_id, 0);
            check_eq("rst_err", m_err, 0);
            check_eq("rst_4k", m_e4k, 0);
        end
        tick();
        rst = 1'b0;
        check_eq("ready_still_low", m_ready, 0);
        tick();
        check_eq("ready_after_rst", m_ready, 1);
        beat_ready = 1'b1;

        // INCR byte burst on the 8-bit bus
        for (int i = 0; i < 4; i++) begin
            exp_addr[i] = 32'h1000 + 32'(i);
            exp_strb[i] = 32'h1;
        end
        send_cmd(0, 5'd3, 32'h1000, 8'd3, 3'd0, 2'd1);
        run_burst("incr8", 5'd3, 4);

        // Unaligned INCR on the 32-bit bus
        exp_addr[0] = 32'h1002; exp_strb[0] = 32'hC;
        exp_addr[1] = 32'h1004; exp_strb[1] = 32'hF;
        exp_addr[2] = 32'h1008; exp_strb[2] = 32'hF;
        send_cmd(1, 5'd17, 32'h1002, 8'd2, 3'd2, 2'd1);
        check_eq("incr32_no4k", m_e4k, 0);
        run_burst("incr32", 5'd17, 3);

        // WRAP of 16 bytes starting near the top of the window
        exp_addr[0] = 32'h38; exp_addr[1] = 32'h3C; exp_addr[2] = 32'h30; exp_addr[3] = 32'h34;
        for (int i = 0; i < 4; i++) exp_strb[i] = 32'hF;
        send_cmd(1, 5'd5, 32'h38, 8'd3, 3'd2, 2'd2);
        run_burst("wrap32", 5'd5, 4);

        // FIXED with a three-cycle stall on beat 1
        send_cmd(0, 5'd30, 32'h20, 8'd2, 3'd0, 2'd0);
        check_eq("fixed_idx0", m_idx, 0);
        check_eq("fixed_addr0", m_addr, 32'h20);
        tick();
        beat_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("stall_valid[%0d]", c), m_valid, 1);
            check_eq($sformatf("stall_addr[%0d]", c), m_addr, 32'h20);
            check_eq($sformatf("stall_idx[%0d]", c), m_idx, 1);
            check_eq($sformatf("stall_strb[%0d]", c), m_strb, 32'h1);
            check_eq($sformatf("stall_last[%0d]", c), m_last, 0);
            check_eq($sformatf("stall_id[%0d]", c), m_id, 30);
            tick();
        end
        beat_ready = 1'b1;
        check_eq("fixed_idx1", m_idx, 1);
        tick();
        check_eq("fixed_idx2", m_idx, 2);
        check_eq("fixed_addr2", m_addr, 32'h20);
        check_eq("fixed_last2", m_last, 1);
        tick();
        check_eq("fixed_valid_after", m_valid, 0);
        check_eq("fixed_ready_after", m_ready, 1);
        $display("txn fixed8: 3 beats with stall");

        // Illegal commands on the 32-bit bus
        illegal_cmd("ill_wrap_len2", 8'd2, 3'd2, 2'd2);
        illegal_cmd("ill_burst3", 8'd1, 3'd0, 2'd3);
        illegal_cmd("ill_size3", 8'd1, 3'd3, 2'd1);

        // INCR crossing a 4 KB page
        exp_addr[0] = 32'h0FFC; exp_strb[0] = 32'h3;
        exp_addr[1] = 32'h0FFE; exp_strb[1] = 32'hC;
        exp_addr[2] = 32'h1000; exp_strb[2] = 32'h3;
        exp_addr[3] = 32'h1002; exp_strb[3] = 32'hC;
        send_cmd(1, 5'd11, 32'h0FFC, 8'd3, 3'd1, 2'd1);
        check_eq("cross_4k", m_e4k, exp_4k);
        check_eq("cross_no_err", m_err, 0);
        check_eq("cross_addr0", m_addr, exp_addr[0]);
        tick();
        check_eq("cross_4k_gone", m_e4k, 0);
        check_eq("cross_addr1", m_addr, exp_addr[1]);
        tick();
        check_eq("cross_addr2", m_addr, exp_addr[2]);
        tick();
        check_eq("cross_addr3", m_addr, exp_addr[3]);
        check_eq("cross_last3", m_last, 1);
        tick();
        check_eq("cross_valid_after", m_valid, 0);
        $display("txn cross4k: 4 beats");

        // Reset during beat 1, then a fresh command
        send_cmd(0, 5'd7, 32'h40, 8'd3, 3'd0, 2'd1);
        tick();
        check_eq("abort_idx1", m_idx, 1);
        rst = 1'b1;
        #1;
        check_eq("abort_valid", m_valid, 0);
        check_eq("abort_ready", m_ready, 0);
        check_eq("abort_addr", m_addr, 0);
        check_eq("abort_idx", m_idx, 0);
        #1;
        rst = 1'b0;
        tick();
        check_eq("abort_ready_back", m_ready, 1);
        exp_addr[0] = 32'h80; exp_strb[0] = 32'h1;
        exp_addr[1] = 32'h81; exp_strb[1] = 32'h1;
        send_cmd(0, 5'd2, 32'h80, 8'd1, 3'd0, 2'd1);
        run_burst("post_rst", 5'd2, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
